// File: rtl/output_frame_sequencer.sv
// Frame-level sequencer between the packed output stream and the VDMA S2MM port.
// Gates beats on start/stop commands, regenerates tuser/tlast and counts completed frames.
module output_frame_sequencer #(
   parameter int AXISOUT_DATA_WIDTH = 32,
   parameter int DST_IMG_WIDTH      = 960,
   parameter int DST_IMG_HEIGHT     = 540
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            ctrl_start,
   input  logic                            ctrl_stop,
   output logic                            ctrl_busy,
   output logic                            frame_done,
   output logic [15:0]                     frame_cnt,
   output logic                            line_err,
   input  logic                            s_axis_tvalid,
   output logic                            s_axis_tready,
   input  logic [AXISOUT_DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic                            s_axis_tlast,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [AXISOUT_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [AXISOUT_DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic [AXISOUT_DATA_WIDTH/8-1:0] m_axis_tstrb,
   output logic                            m_axis_tlast,
   output logic                            m_axis_tuser
);

   localparam int PPB = (AXISOUT_DATA_WIDTH/8)/3;
   localparam int BPL = DST_IMG_WIDTH/PPB;
   localparam int BW  = $clog2(BPL) + 1;
   localparam int LW  = $clog2(DST_IMG_HEIGHT) + 1;
   localparam logic [BW-1:0] BEAT_LAST = BW'(BPL - 1);
   localparam logic [LW-1:0] LINE_LAST = LW'(DST_IMG_HEIGHT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } state_t;

   state_t        state_q, state_d;
   logic [BW-1:0] beat_cnt;
   logic [LW-1:0] line_cnt;
   logic          at_boundary, at_beat_last, at_line_last;
   logic          in_hs, out_hs, frame_end;
   logic          m_last_line;
   logic          accept_ok;

   assign at_boundary  = (beat_cnt == '0) && (line_cnt == '0);
   assign at_beat_last = (beat_cnt == BEAT_LAST);
   assign at_line_last = (line_cnt == LINE_LAST);

   assign in_hs     = s_axis_tvalid & s_axis_tready;
   assign out_hs    = m_axis_tvalid & m_axis_tready;
   assign frame_end = out_hs & m_axis_tlast & m_last_line;

   assign m_axis_tkeep = '1;
   assign m_axis_tstrb = '1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // DRAIN only admits the rest of the current frame, never the first beat of a new one.
   always_comb begin
      state_d   = state_q;
      ctrl_busy = 1'b0;
      accept_ok = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (ctrl_start && !ctrl_stop) state_d = ST_RUN;
         end
         ST_RUN: begin
            ctrl_busy = 1'b1;
            accept_ok = 1'b1;
            if (ctrl_stop) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            ctrl_busy = 1'b1;
            accept_ok = !at_boundary;
            if (ctrl_start) begin
               state_d = ST_RUN;
            end else if (at_boundary && !m_axis_tvalid) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign s_axis_tready = (~m_axis_tvalid | m_axis_tready) & accept_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt <= '0;
         line_cnt <= '0;
      end else if (in_hs) begin
         if (at_beat_last) begin
            beat_cnt <= '0;
            line_cnt <= at_line_last ? '0 : line_cnt + 1'b1;
         end else begin
            beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tuser  <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_last_line   <= 1'b0;
      end else if (in_hs) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= s_axis_tdata;
         m_axis_tuser  <= at_boundary;
         m_axis_tlast  <= at_beat_last;
         m_last_line   <= at_line_last;
      end else if (out_hs) begin
         m_axis_tvalid <= 1'b0;
      end
   end

   // A start clears the sticky flag, but a mismatch seen in the same cycle still registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         line_err <= 1'b0;
      end else begin
         if (ctrl_start) line_err <= 1'b0;
         if (in_hs && (s_axis_tlast != at_beat_last)) line_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_done <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         frame_done <= frame_end;
         if (frame_end) frame_cnt <= frame_cnt + 1'b1;
      end
   end

endmodule
